// File: rtl/pim_axi_pkg.sv
// pim_axi_pkg: AXI burst/response encodings, bridge state enum and beat-address step helper
package pim_axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_DATA,
        ST_W_NAT,
        ST_W_RESP,
        ST_R_NAT,
        ST_R_DATA
    } state_e;

    // Byte distance between consecutive beats: 1<<size for INCR, 0 for FIXED (and anything else)
    function automatic logic [7:0] beat_step(input logic [2:0] size, input logic [1:0] burst);
        return (burst == BURST_INCR) ? 8'd1 << size : 8'd0;
    endfunction
endpackage

// File: rtl/axi_slave_native_bridge_if.sv
// axi_slave_native_bridge_if: AXI4 slave channels plus native single-beat request port
//   slave  modport: bridge side (AXI inputs/ready-resp outputs, drives native request)
//   master modport: initiator/target side (drives AXI, answers native request)
interface axi_slave_native_bridge_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     s_axi_awid;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic [2:0]              s_axi_awsize;
    logic [1:0]              s_axi_awburst;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wlast;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [ID_WIDTH-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ID_WIDTH-1:0]     s_axi_arid;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic [2:0]              s_axi_arsize;
    logic [1:0]              s_axi_arburst;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ID_WIDTH-1:0]     s_axi_rid;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic                    nat_valid;
    logic                    nat_we;
    logic [ADDR_WIDTH-1:0]   nat_addr;
    logic [DATA_WIDTH-1:0]   nat_wdata;
    logic [DATA_WIDTH/8-1:0] nat_wstrb;
    logic                    nat_ready;
    logic [DATA_WIDTH-1:0]   nat_rdata;
    logic                    nat_err;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output nat_valid, nat_we, nat_addr, nat_wdata, nat_wstrb,
        input  nat_ready, nat_rdata, nat_err
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  nat_valid, nat_we, nat_addr, nat_wdata, nat_wstrb,
        output nat_ready, nat_rdata, nat_err
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: per-beat address/last/error tracker for one AXI burst
//   load: capture start_addr/len/size/burst; advance: step to next beat
//   addr: current beat address; last: current beat is final; err: burst unsupported (WRAP or oversize)
module axi_burst_addr_gen
    import pim_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  err
);
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        if (load) begin
            addr_d  = start_addr;
            len_d   = len;
            cnt_d   = '0;
            size_d  = size;
            burst_d = burst;
        end else if (advance) begin
            // address arithmetic wraps naturally at 2^ADDR_WIDTH, no 4KB check
            addr_d = addr_q + ADDR_WIDTH'(beat_step(size_q, burst_q));
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign addr = addr_q;
    assign last = cnt_q == len_q;
    assign err  = (burst_q == BURST_WRAP) || (int'(size_q) > $clog2(DATA_WIDTH / 8));
endmodule

// File: rtl/axi_slave_native_bridge.sv
// axi_slave_native_bridge: AXI4 slave that splits bursts into single-beat native valid/ready requests
//   clk/rst: clock and async active-high reset
//   bus: AXI AW/W/B/AR/R slave channels and native request port (one transaction, one request in flight)
module axi_slave_native_bridge
    import pim_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input logic                     clk,
    input logic                     rst,
    axi_slave_native_bridge_if.slave bus
);
    state_e                  state_q, state_d;
    logic                    prio_rd_q, prio_rd_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    grant_r, grant_w, load, advance;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic                    beat_last, burst_err;

    // prio_rd_q only decides ties; a lone request is granted regardless
    assign grant_r = !rst && state_q == ST_IDLE && bus.s_axi_arvalid && (!bus.s_axi_awvalid || prio_rd_q);
    assign grant_w = !rst && state_q == ST_IDLE && bus.s_axi_awvalid && !grant_r;

    axi_burst_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .start_addr(grant_w ? bus.s_axi_awaddr  : bus.s_axi_araddr),
        .len       (grant_w ? bus.s_axi_awlen   : bus.s_axi_arlen),
        .size      (grant_w ? bus.s_axi_awsize  : bus.s_axi_arsize),
        .burst     (grant_w ? bus.s_axi_awburst : bus.s_axi_arburst),
        .addr      (beat_addr),
        .last      (beat_last),
        .err       (burst_err)
    );

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        id_d      = id_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        load      = 1'b0;
        advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_r || grant_w) begin
                    load    = 1'b1;
                    id_d    = grant_w ? bus.s_axi_awid : bus.s_axi_arid;
                    err_d   = 1'b0;
                    state_d = grant_w ? ST_W_DATA : ST_R_NAT;
                    if (bus.s_axi_awvalid && bus.s_axi_arvalid) prio_rd_d = !grant_r;
                end
            end
            ST_W_DATA: begin
                if (bus.s_axi_wvalid) begin
                    wdata_d = bus.s_axi_wdata;
                    wstrb_d = bus.s_axi_wstrb;
                    // beat count ends the burst; a wrong wlast only poisons the response
                    if (bus.s_axi_wlast != beat_last) err_d = 1'b1;
                    if (!burst_err) state_d = ST_W_NAT;
                    else if (beat_last) state_d = ST_W_RESP;
                    else advance = 1'b1;
                end
            end
            ST_W_NAT: begin
                if (bus.nat_ready) begin
                    err_d   = err_q | bus.nat_err;
                    advance = 1'b1;
                    state_d = beat_last ? ST_W_RESP : ST_W_DATA;
                end
            end
            ST_W_RESP: begin
                if (bus.s_axi_bready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_R_NAT: begin
                // unsupported bursts skip the native side and return zero data
                if (burst_err) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = ST_R_DATA;
                end else if (bus.nat_ready) begin
                    rdata_d = bus.nat_rdata;
                    rresp_d = bus.nat_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = ST_R_DATA;
                end
            end
            ST_R_DATA: begin
                if (bus.s_axi_rready) begin
                    advance = !beat_last;
                    state_d = beat_last ? ST_IDLE : ST_R_NAT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            id_q      <= id_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.s_axi_awready = grant_w;
    assign bus.s_axi_arready = grant_r;
    assign bus.s_axi_wready  = state_q == ST_W_DATA;
    assign bus.s_axi_bvalid  = state_q == ST_W_RESP;
    assign bus.s_axi_bid     = id_q;
    assign bus.s_axi_bresp   = (state_q == ST_W_RESP && (err_q || burst_err)) ? RESP_SLVERR : RESP_OKAY;
    assign bus.s_axi_rvalid  = state_q == ST_R_DATA;
    assign bus.s_axi_rid     = id_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.s_axi_rlast   = state_q == ST_R_DATA && beat_last;
    assign bus.nat_valid     = state_q == ST_W_NAT || (state_q == ST_R_NAT && !burst_err);
    assign bus.nat_we        = state_q == ST_W_NAT;
    assign bus.nat_addr      = beat_addr;
    assign bus.nat_wdata     = wdata_q;
    assign bus.nat_wstrb     = state_q == ST_W_NAT ? wstrb_q : '0;
endmodule

// File: tb/tb_axi_slave_native_bridge.sv
// tb_axi_slave_native_bridge: directed + randomized bench with a burst-level reference model
module tb_axi_slave_native_bridge;
    import pim_axi_pkg::*;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   err_idx = -1;
    int   nat_delay = 0;
    bit   rand_delay = 1'b0;
    req_t          req_q[$];
    logic [DW-1:0] rsp_q[$];
    logic [DW-1:0] exp_wd[$];
    logic [SW-1:0] exp_ws[$];

    always #5 clk = ~clk;

    axi_slave_native_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_slave_native_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // native target: accepts after nat_delay waiting cycles, returns random data, flags error on request err_idx
    initial begin : nat_target
        int   w;
        req_t r;
        w = 0;
        bus.nat_ready = 1'b0;
        bus.nat_rdata = '0;
        bus.nat_err   = 1'b0;
        forever begin
            @(negedge clk);
            bus.nat_ready = 1'b0;
            bus.nat_err   = 1'b0;
            if (rst || !bus.nat_valid) w = 0;
            else if (w >= nat_delay) begin
                r.we = bus.nat_we;
                r.addr = bus.nat_addr;
                r.wdata = bus.nat_wdata;
                r.wstrb = bus.nat_wstrb;
                req_q.push_back(r);
                bus.nat_rdata = rand_data();
                rsp_q.push_back(bus.nat_rdata);
                bus.nat_err   = (req_q.size() - 1) == err_idx;
                bus.nat_ready = 1'b1;
                w = 0;
                if (rand_delay) nat_delay = int'($urandom_range(0, 3));
            end else w++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    function automatic bit unsupported(input int size, input logic [1:0] burst);
        return (burst == BURST_WRAP) || (size > $clog2(DW / 8));
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int i, input int size, input logic [1:0] burst);
        return a + ((burst == BURST_INCR) ? (AW'(i) << size) : AW'(0));
    endfunction

    task automatic start_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len, input int size, input logic [1:0] burst);
        bus.s_axi_awid = id;
        bus.s_axi_awaddr = a;
        bus.s_axi_awlen = 8'(len);
        bus.s_axi_awsize = 3'(size);
        bus.s_axi_awburst = burst;
        bus.s_axi_awvalid = 1'b1;
    endtask

    task automatic start_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len, input int size, input logic [1:0] burst);
        bus.s_axi_arid = id;
        bus.s_axi_araddr = a;
        bus.s_axi_arlen = 8'(len);
        bus.s_axi_arsize = 3'(size);
        bus.s_axi_arburst = burst;
        bus.s_axi_arvalid = 1'b1;
    endtask

    task automatic wait_aw(input string tag);
        int t = 0;
        #1;
        while (!bus.s_axi_awready && t < 200) begin @(negedge clk); #1; t++; end
        chk({tag, "_awready"}, DW'(bus.s_axi_awready), DW'(1));
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic wait_ar(input string tag);
        int t = 0;
        #1;
        while (!bus.s_axi_arready && t < 200) begin @(negedge clk); #1; t++; end
        chk({tag, "_arready"}, DW'(bus.s_axi_arready), DW'(1));
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic w_phase(input string tag, input int len, input int wl_bad, input bit fixed);
        exp_wd.delete();
        exp_ws.delete();
        for (int i = 0; i <= len; i++) begin
            int t = 0;
            bus.s_axi_wdata  = fixed ? {64{8'hA5}} : rand_data();
            bus.s_axi_wstrb  = fixed ? '1 : SW'({$urandom, $urandom});
            bus.s_axi_wlast  = (i == len) ^ (i == wl_bad);
            bus.s_axi_wvalid = 1'b1;
            exp_wd.push_back(bus.s_axi_wdata);
            exp_ws.push_back(bus.s_axi_wstrb);
            #1;
            while (!bus.s_axi_wready && t < 200) begin @(negedge clk); #1; t++; end
            chk({tag, "_wready"}, DW'(bus.s_axi_wready), DW'(1));
            @(negedge clk);
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
    endtask

    task automatic b_phase(input string tag, input logic [IW-1:0] id, input logic [1:0] resp);
        int t = 0;
        bus.s_axi_bready = 1'b1;
        #1;
        while (!bus.s_axi_bvalid && t < 400) begin @(negedge clk); #1; t++; end
        chk({tag, "_bvalid"}, DW'(bus.s_axi_bvalid), DW'(1));
        chk({tag, "_bid"}, DW'(bus.s_axi_bid), DW'(id));
        chk({tag, "_bresp"}, DW'(bus.s_axi_bresp), DW'(resp));
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        #1;
        chk({tag, "_bvalid_drop"}, DW'(bus.s_axi_bvalid), DW'(0));
    endtask

    task automatic r_phase(input string tag, input logic [IW-1:0] id, input int len, input bit bb, input int e_idx, input int stall_beat, input int stall_n);
        for (int i = 0; i <= len; i++) begin
            int t = 0;
            logic [DW-1:0] snap;
            #1;
            while (!bus.s_axi_rvalid && t < 400) begin @(negedge clk); #1; t++; end
            chk({tag, "_rvalid"}, DW'(bus.s_axi_rvalid), DW'(1));
            chk({tag, "_rid"}, DW'(bus.s_axi_rid), DW'(id));
            chk({tag, "_rlast"}, DW'(bus.s_axi_rlast), DW'(i == len));
            chk({tag, "_rresp"}, DW'(bus.s_axi_rresp), DW'((bb || i == e_idx) ? RESP_SLVERR : RESP_OKAY));
            chk({tag, "_rdata"}, bus.s_axi_rdata, bb ? '0 : (i < rsp_q.size() ? rsp_q[i] : 'x));
            snap = bus.s_axi_rdata;
            if (i == stall_beat) begin
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    #1;
                    chk({tag, "_stall_rdata"}, bus.s_axi_rdata, snap);
                    chk({tag, "_stall_rvalid"}, DW'(bus.s_axi_rvalid), DW'(1));
                end
            end
            bus.s_axi_rready = 1'b1;
            @(negedge clk);
            bus.s_axi_rready = 1'b0;
        end
    endtask

    task automatic nat_check(input string tag, input bit we, input logic [AW-1:0] a, input int len, input int size, input logic [1:0] burst);
        int n;
        n = unsupported(size, burst) ? 0 : len + 1;
        chk({tag, "_nat_count"}, DW'(req_q.size()), DW'(n));
        for (int i = 0; i < n && i < req_q.size(); i++) begin
            chk({tag, "_nat_addr"}, DW'(req_q[i].addr), DW'(model_addr(a, i, size, burst)));
            chk({tag, "_nat_we"}, DW'(req_q[i].we), DW'(we));
            chk({tag, "_nat_wstrb"}, DW'(req_q[i].wstrb), we ? DW'(exp_ws[i]) : '0);
            if (we) chk({tag, "_nat_wdata"}, req_q[i].wdata, exp_wd[i]);
        end
    endtask

    task automatic do_write(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] a, input int len, input int size, input logic [1:0] burst, input int wl_bad, input bit fixed, input int e_idx);
        bit bb;
        bb = unsupported(size, burst);
        err_idx = e_idx;
        req_q.delete();
        rsp_q.delete();
        start_aw(id, a, len, size, burst);
        wait_aw(tag);
        w_phase(tag, len, wl_bad, fixed);
        b_phase(tag, id, (bb || wl_bad >= 0 || (e_idx >= 0 && e_idx <= len)) ? RESP_SLVERR : RESP_OKAY);
        nat_check(tag, 1'b1, a, len, size, burst);
    endtask

    task automatic do_read(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] a, input int len, input int size, input logic [1:0] burst, input int e_idx, input int stall_beat, input int stall_n);
        err_idx = e_idx;
        req_q.delete();
        rsp_q.delete();
        start_ar(id, a, len, size, burst);
        wait_ar(tag);
        r_phase(tag, id, len, unsupported(size, burst), e_idx, stall_beat, stall_n);
        nat_check(tag, 1'b0, a, len, size, burst);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awready"}, DW'(bus.s_axi_awready), DW'(0));
        chk({tag, "_arready"}, DW'(bus.s_axi_arready), DW'(0));
        chk({tag, "_wready"}, DW'(bus.s_axi_wready), DW'(0));
        chk({tag, "_bvalid"}, DW'(bus.s_axi_bvalid), DW'(0));
        chk({tag, "_rvalid"}, DW'(bus.s_axi_rvalid), DW'(0));
        chk({tag, "_nat_valid"}, DW'(bus.nat_valid), DW'(0));
        chk({tag, "_bresp"}, DW'(bus.s_axi_bresp), DW'(0));
        chk({tag, "_rresp"}, DW'(bus.s_axi_rresp), DW'(0));
        chk({tag, "_rid"}, DW'(bus.s_axi_rid), DW'(0));
        chk({tag, "_rdata"}, bus.s_axi_rdata, '0);
        chk({tag, "_nat_addr"}, DW'(bus.nat_addr), DW'(0));
        chk({tag, "_nat_wdata"}, bus.nat_wdata, '0);
    endtask

    initial begin : main
        int len, size, e, wl;
        bit seen;
        logic [1:0] burst;
        logic [IW-1:0] id;
        logic [AW-1:0] a;
        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
        bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
        bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        nat_delay = 3;
        do_write("wr_single", 8'h11, 32'h100, 0, 6, BURST_INCR, -1, 1'b1, -1);

        nat_delay = 1;
        do_read("rd_incr", 8'h22, 32'h1000, 3, 6, BURST_INCR, -1, 1, 5);

        do_write("wr_fixed", 8'h33, 32'h200, 2, 6, BURST_FIXED, -1, 1'b0, 1);
        do_read("rd_wrap", 8'h44, 32'h300, 1, 6, BURST_WRAP, -1, -1, 0);
        do_write("wr_early_wlast", 8'h45, 32'h340, 2, 6, BURST_INCR, 0, 1'b0, -1);
        do_write("wr_no_wlast", 8'h46, 32'h380, 1, 6, BURST_INCR, 1, 1'b0, -1);
        do_write("wr_oversize", 8'h47, 32'h3C0, 1, 7, BURST_INCR, -1, 1'b0, -1);
        do_read("rd_addr_wrap", 8'h48, 32'hFFFF_FFC0, 1, 6, BURST_INCR, 0, -1, 0);

        // contention twice: read wins first, then the write
        err_idx = -1;
        req_q.delete();
        rsp_q.delete();
        start_aw(8'h55, 32'h400, 0, 6, BURST_INCR);
        start_ar(8'h66, 32'h500, 0, 6, BURST_INCR);
        #1;
        chk("arb1_aw_blocked", DW'(bus.s_axi_awready), DW'(0));
        wait_ar("arb1");
        r_phase("arb1", 8'h66, 0, 1'b0, -1, -1, 0);
        nat_check("arb1", 1'b0, 32'h500, 0, 6, BURST_INCR);
        req_q.delete();
        rsp_q.delete();
        start_ar(8'h77, 32'h600, 0, 6, BURST_INCR);
        #1;
        chk("arb2_ar_blocked", DW'(bus.s_axi_arready), DW'(0));
        wait_aw("arb2");
        w_phase("arb2", 0, -1, 1'b0);
        b_phase("arb2", 8'h55, RESP_OKAY);
        nat_check("arb2", 1'b1, 32'h400, 0, 6, BURST_INCR);
        req_q.delete();
        rsp_q.delete();
        wait_ar("arb3");
        r_phase("arb3", 8'h77, 0, 1'b0, -1, -1, 0);
        nat_check("arb3", 1'b0, 32'h600, 0, 6, BURST_INCR);

        // reset in the middle of a 4-beat read
        nat_delay = 2;
        req_q.delete();
        rsp_q.delete();
        start_ar(8'h88, 32'h2000, 3, 6, BURST_INCR);
        wait_ar("rst_rd");
        begin
            int t = 0;
            #1;
            while (!bus.s_axi_rvalid && t < 200) begin @(negedge clk); #1; t++; end
            chk("rst_rd_beat1", DW'(bus.s_axi_rvalid), DW'(1));
            bus.s_axi_rready = 1'b1;
            @(negedge clk);
            bus.s_axi_rready = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.s_axi_rvalid || bus.nat_valid) seen = 1'b1;
        end
        chk("rst_no_resp", DW'(seen), DW'(0));
        do_read("rd_after_rst", 8'h99, 32'h3000, 1, 6, BURST_INCR, -1, -1, 0);

        // randomized bursts
        rand_delay = 1'b1;
        for (int n = 0; n < 12; n++) begin
            len = int'($urandom_range(0, 3));
            size = int'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            e = int'($urandom_range(0, 4)) - 1;
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (wl > len) wl = -1;
            id = IW'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) do_write("rand_wr", id, a, len, size, burst, wl, 1'b0, e);
            else do_read("rand_rd", id, a, len, size, burst, e, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
